// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester, datapath and control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding for gcd_client, and default WIDTH / LAT_W /
// TIMEOUT values that the GCD datapath and control use as well.
package gcd_pkg;

    // Requester FSM state encoding. The values are fixed (IDLE=0 .. RESP=3)
    // so that debug taps and the GCD control agree on what they mean.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } gcd_state_e;

    // Default operand/result width.
    localparam int GCD_WIDTH   = 16;
    // Default latency counter width. The counter saturates at 2^LAT_W-1.
    localparam int GCD_LAT_W   = 8;
    // Default number of BUSY cycles before a request is abandoned.
    // It must not exceed 2^LAT_W-1 so that it can be reported in resp_latency.
    localparam int GCD_TIMEOUT = 200;

endpackage : gcd_pkg

// File: rtl/gcd_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Latency: count reflects clr/en one cycle after they are asserted.
// Backpressure: none; when en is held high at full scale, count stays at all-ones.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high; forces count to 0
//   clr    - synchronous clear; takes priority over en
//   en     - increment enable
//   count  - current value, LAT_W bits
module gcd_sat_counter
    import gcd_pkg::*;
#(
    parameter int LAT_W = GCD_LAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [LAT_W-1:0] count
);

    localparam logic [LAT_W-1:0] COUNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != COUNT_MAX)) begin
            count <= count + LAT_W'(1);
        end
    end

endmodule : gcd_sat_counter

// File: rtl/gcd_client.sv
// Requester-side controller for the sequential GCD unit: issues one operand pair, then captures the result and its latency.
// Latency: ISSUE one cycle after acceptance, result captured in the gcd_result_rdy cycle, response is valid on the next cycle.
// Backpressure: one request in flight. req_ready is high only in IDLE, and RESP holds the response until resp_ready.
//
// Ports:
//   clk, reset                          - clock; synchronous active-high reset
//   req_valid/req_ready, req_a, req_b   - upstream operand pair (valid/ready)
//   gcd_input_available, gcd_a, gcd_b   - operand load pulse and operands to the GCD unit
//   gcd_result_rdy, gcd_result          - result handshake from the GCD unit
//   gcd_result_taken                    - result consumed (also used to flush stale results)
//   resp_valid/resp_ready               - downstream response (valid/ready)
//   resp_gcd, resp_latency, resp_timeout- captured result, BUSY cycle count, abort flag
//   err                                 - sticky timeout indication, cleared only by reset
module gcd_client
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int LAT_W   = GCD_LAT_W,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,

    output logic             gcd_input_available,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_result_rdy,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             gcd_result_taken,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_gcd,
    output logic [LAT_W-1:0] resp_latency,
    output logic             resp_timeout,
    output logic             err
);

    // Abort when the counter reaches TIMEOUT-1 in BUSY. At that point
    // TIMEOUT BUSY cycles have elapsed because the counter starts at 0.
    localparam logic [LAT_W-1:0] TIMEOUT_LAST = LAT_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] TIMEOUT_VAL  = LAT_W'(TIMEOUT);

    gcd_state_e       state_q;
    gcd_state_e       state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] resp_gcd_q;
    logic [LAT_W-1:0] resp_lat_q;
    logic             resp_to_q;
    logic             err_q;

    logic             load_req;
    logic             cap_result;
    logic             cap_timeout;
    logic             cnt_clr;
    logic             cnt_en;
    logic [LAT_W-1:0] lat_cnt;

    // Latency / timeout counter. It is cleared in ISSUE, so the first BUSY
    // cycle sees 0. It then counts once per BUSY cycle.
    gcd_sat_counter #(
        .LAT_W (LAT_W)
    ) u_lat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (lat_cnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d             = state_q;
        req_ready           = 1'b0;
        gcd_input_available = 1'b0;
        gcd_result_taken    = 1'b0;
        resp_valid          = 1'b0;
        load_req            = 1'b0;
        cap_result          = 1'b0;
        cap_timeout         = 1'b0;
        cnt_clr             = 1'b0;
        cnt_en              = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                // A result that arrives after its request was abandoned is
                // acknowledged and dropped, so the GCD unit is not left stuck.
                gcd_result_taken = gcd_result_rdy;
                if (req_valid) begin
                    load_req = 1'b1;
                    state_d  = ISSUE;
                end
            end

            ISSUE: begin
                // A single-cycle load pulse. The GCD unit latches gcd_a/gcd_b on this edge.
                gcd_input_available = 1'b1;
                cnt_clr             = 1'b1;
                state_d             = BUSY;
            end

            BUSY: begin
                cnt_en = 1'b1;
                // Check for a result first, so that a result arriving in the
                // timeout cycle is still delivered as a normal response.
                if (gcd_result_rdy) begin
                    gcd_result_taken = 1'b1;
                    cap_result       = 1'b1;
                    state_d          = RESP;
                end else if (lat_cnt == TIMEOUT_LAST) begin
                    cap_timeout = 1'b1;
                    state_d     = RESP;
                end
            end

            RESP: begin
                resp_valid       = 1'b1;
                gcd_result_taken = gcd_result_rdy;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand and response capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            resp_gcd_q <= '0;
            resp_lat_q <= '0;
            resp_to_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (load_req) begin
                a_q <= req_a;
                b_q <= req_b;
            end
            if (cap_result) begin
                resp_gcd_q <= gcd_result;
                resp_lat_q <= lat_cnt;
                resp_to_q  <= 1'b0;
            end else if (cap_timeout) begin
                resp_gcd_q <= '0;
                resp_lat_q <= TIMEOUT_VAL;
                resp_to_q  <= 1'b1;
                err_q      <= 1'b1;
            end
        end
    end

    // The operands are driven from the holding registers at all times.
    // They stay stable from ISSUE through BUSY because a_q/b_q load only in IDLE.
    assign gcd_a        = a_q;
    assign gcd_b        = b_q;
    assign resp_gcd     = resp_gcd_q;
    assign resp_latency = resp_lat_q;
    assign resp_timeout = resp_to_q;
    assign err          = err_q;

endmodule : gcd_client

// File: tb/tb_gcd_client.sv
// Bench for gcd_client. A behavioural GCD unit stub is placed behind the DUT, and a scoreboard checks each response.
// Expected responses are queued at request acceptance and popped when the response handshake completes.
// The stub's delay to result_rdy is programmable and it can also never respond, which covers the timeout and stale-flush cases.
module tb_gcd_client;

    localparam int W  = 16;
    localparam int LW = 8;
    localparam int TO = 10;

    typedef struct packed {
        logic [W-1:0]  gcd;
        logic [LW-1:0] lat;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic          gcd_input_available;
    logic [W-1:0]  gcd_a;
    logic [W-1:0]  gcd_b;
    logic          gcd_result_rdy;
    logic [W-1:0]  gcd_result;
    logic          gcd_result_taken;
    logic          resp_valid;
    logic          resp_ready;
    logic [W-1:0]  resp_gcd;
    logic [LW-1:0] resp_latency;
    logic          resp_timeout;
    logic          err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ia_cnt   = 0;
    bit   err_exp  = 1'b0;
    exp_t exp_q[$];

    // Stub GCD unit
    logic         stub_busy;
    int           stub_cnt;
    logic [W-1:0] stub_res;
    int           stub_delay;
    bit           stub_never;

    always #5 clk = ~clk;

    gcd_client #(
        .WIDTH   (W),
        .LAT_W   (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_a               (req_a),
        .req_b               (req_b),
        .gcd_input_available (gcd_input_available),
        .gcd_a               (gcd_a),
        .gcd_b               (gcd_b),
        .gcd_result_rdy      (gcd_result_rdy),
        .gcd_result          (gcd_result),
        .gcd_result_taken    (gcd_result_taken),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_gcd            (resp_gcd),
        .resp_latency        (resp_latency),
        .resp_timeout        (resp_timeout),
        .err                 (err)
    );

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stub: the operands are loaded on the input_available edge. rdy rises stub_delay
    // cycles later and is held until the DUT acknowledges it with result_taken.
    always @(posedge clk) begin
        if (reset) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            stub_res  <= '0;
        end else if (gcd_input_available) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_delay;
            stub_res  <= gcd_ref(gcd_a, gcd_b);
        end else if (gcd_result_rdy && gcd_result_taken) begin
            stub_busy <= 1'b0;
        end else if (stub_busy && stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign gcd_result_rdy = stub_busy && !stub_never && (stub_cnt == 0);
    assign gcd_result     = gcd_result_rdy ? stub_res : '0;

    always @(posedge clk) begin
        if (gcd_input_available) ia_cnt <= ia_cnt + 1;
    end

    // Response monitor: a handshake is seen at the negedge before the accepting edge.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_gcd", 32'(resp_gcd), 32'(e.gcd));
                check("resp_latency", 32'(resp_latency), 32'(e.lat));
                check("resp_timeout", 32'(resp_timeout), 32'(e.to));
            end
        end
    end

    task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                          input bit never, input int hold, input bit exp_stale);
        exp_t e;
        bit   accepted;
        bit   got_resp;
        bit   seen_rdy;
        bit   stale_seen;
        int   ia0;
        accepted   = 1'b0;
        got_resp   = 1'b0;
        seen_rdy   = 1'b0;
        stale_seen = 1'b0;

        @(posedge clk); #1;
        stub_delay = delay;
        stub_never = never;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        if (never || delay >= TO) begin
            e.gcd = '0;
            e.lat = LW'(TO);
            e.to  = 1'b1;
        end else begin
            e.gcd = gcd_ref(a, b);
            e.lat = LW'(delay);
            e.to  = 1'b0;
        end
        ia0 = ia_cnt;

        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        check("req_accept", 32'(accepted), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!accepted) return;
        exp_q.push_back(e);
        if (e.to) err_exp = 1'b1;

        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (gcd_result_rdy && !seen_rdy && !resp_valid) begin
                check("taken_on_rdy", 32'(gcd_result_taken), 32'd1);
                seen_rdy = 1'b1;
            end
            if (resp_valid) begin
                got_resp = 1'b1;
                break;
            end
        end
        check("resp_seen", 32'(got_resp), 32'd1);
        if (!got_resp) return;
        check("issue_pulses", 32'(ia_cnt - ia0), 32'd1);
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
        check("err_in_resp", 32'(err), 32'(err_exp));

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_gcd", 32'(resp_gcd), 32'(e.gcd));
            check("hold_lat", 32'(resp_latency), 32'(e.lat));
            check("hold_to", 32'(resp_timeout), 32'(e.to));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            if (gcd_result_rdy) begin
                check("stale_taken", 32'(gcd_result_taken), 32'd1);
                stale_seen = 1'b1;
            end
        end
        if (exp_stale) check("stale_seen", 32'(stale_seen), 32'd1);
        if (hold > 0) check("issue_pulses_held", 32'(ia_cnt - ia0), 32'd1);

        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_resp_valid", 32'(resp_valid), 32'd0);
        check("err_sticky", 32'(err), 32'(err_exp));
    endtask

    task automatic reset_mid_busy();
        bit issued;
        int resp_cycles;
        issued      = 1'b0;
        resp_cycles = 0;
        @(posedge clk); #1;
        stub_never = 1'b1;
        stub_delay = 0;
        req_a      = 16'd30;
        req_b      = 16'd12;
        req_valid  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (gcd_input_available) begin
                issued = 1'b1;
                break;
            end
            if (req_ready) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("rst_issue", 32'(issued), 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        err_exp = 1'b0;
        stub_never = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_taken", 32'(gcd_result_taken), 32'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (resp_valid) resp_cycles++;
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("rst_no_resp", 32'(resp_cycles), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        stub_delay = 0;
        stub_never = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state_req_ready", 32'(req_ready), 32'd1);
        check("rst_state_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_state_ia", 32'(gcd_input_available), 32'd0);
        check("rst_state_taken", 32'(gcd_result_taken), 32'd0);
        check("rst_state_err", 32'(err), 32'd0);
        check("rst_state_gcd_a", 32'(gcd_a), 32'd0);
        check("rst_state_resp_gcd", 32'(resp_gcd), 32'd0);
        check("rst_state_resp_lat", 32'(resp_latency), 32'd0);
        check("rst_state_resp_to", 32'(resp_timeout), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_req(16'd48,    16'd18, 3,  1'b0, 0, 1'b0);
        do_req(16'd18,    16'd48, 0,  1'b0, 0, 1'b0);
        do_req(16'd7,     16'd0,  1,  1'b0, 0, 1'b0);
        do_req(16'd0,     16'd0,  2,  1'b0, 0, 1'b0);
        // Result in the same cycle as the timeout: the result is delivered.
        do_req(16'd65535, 16'd1,  TO - 1, 1'b0, 0, 1'b0);
        // Back-pressure: resp_ready is held low for 5 cycles.
        do_req(16'd100,   16'd75, 4,  1'b0, 5, 1'b0);
        // The stub never responds, so the request times out.
        do_req(16'd12,    16'd8,  0,  1'b1, 2, 1'b0);
        // Timeout, then a late result arrives while the response waits in RESP.
        do_req(16'd21,    16'd14, TO + 2, 1'b0, 6, 1'b1);
        // err must stay set across later good requests.
        do_req(16'd35,    16'd21, 2,  1'b0, 1, 1'b0);
        reset_mid_busy();
        do_req(16'd9,     16'd6,  1,  1'b0, 0, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gcd_client

// File: doc/gcd_client.md
Name: gcd_client

Overview:
Requester-side controller for the sequential GCD unit. It accepts operand pairs from an upstream valid/ready source and drives the GCD unit's input_available / result_rdy / result_taken handshake. It captures each result together with its measured latency and offers it downstream on a valid/ready port. It sits between the test or host logic and the GCD datapath/control pair, and replaces ad-hoc stimulus code.

Parameters:
WIDTH, 16, operand and result width in bits.
LAT_W, 8, width of the latency counter; the counter saturates at 2^LAT_W-1.
TIMEOUT, 200, number of BUSY cycles without gcd_result_rdy before the request is aborted; must be ≤ 2^LAT_W-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  upstream operand pair valid.
req_ready  out  1  block can accept a pair.
req_a  in  WIDTH  operand A.
req_b  in  WIDTH  operand B.
gcd_input_available  out  1  to GCD unit: operands valid this cycle.
gcd_a  out  WIDTH  operand A to the GCD datapath.
gcd_b  out  WIDTH  operand B to the GCD datapath.
gcd_result_rdy  in  1  from GCD unit: result ready.
gcd_result  in  WIDTH  GCD result.
gcd_result_taken  out  1  to GCD unit: result consumed.
resp_valid  out  1  downstream response valid.
resp_ready  in  1  downstream accepts the response.
resp_gcd  out  WIDTH  captured result; 0 on timeout.
resp_latency  out  LAT_W  BUSY cycles from issue to result.
resp_timeout  out  1  the response is an aborted request.
err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on reset. The state machine has 4 states, encoded IDLE=0, ISSUE=1, BUSY=2, RESP=3.
- Reset values:
  - state = IDLE.
  - All outputs are 0, except req_ready = 1 (req_ready is decoded from IDLE).
  - Operand, result and latency registers = 0.
  - err = 0.
- Reset asserted in any state returns the block to IDLE on the next edge. Any in-flight request is dropped with no response. The GCD unit shares the same reset.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_a/req_b into a_q/b_q and go to ISSUE.
- ISSUE:
  - gcd_input_available = 1 for exactly one cycle, with gcd_a = a_q and gcd_b = b_q.
  - The GCD unit loads on this edge.
  - Clear the latency counter and go to BUSY unconditionally.
- gcd_a/gcd_b are driven from a_q/b_q in all states; they are stable from ISSUE through BUSY.
- BUSY:
  - The counter increments each cycle and saturates.
  - If gcd_result_rdy is high: gcd_result_taken = 1 combinationally in the same cycle. Capture resp_gcd = gcd_result, resp_latency = counter, and resp_timeout = 0, then go to RESP.
  - Otherwise, if counter == TIMEOUT-1: set resp_gcd = 0, resp_latency = TIMEOUT, resp_timeout = 1, and err = 1, then go to RESP.
  - If result and timeout occur in the same cycle, the result wins.
- RESP:
  - resp_valid = 1. resp_gcd, resp_latency and resp_timeout are held stable until the response is accepted.
  - On resp_ready, go to IDLE. No new request is accepted in the same cycle (req_ready = 0 in RESP).
- Stale-result flush:
  - In IDLE and RESP, if gcd_result_rdy is high (a late result after a timeout), assert gcd_result_taken and discard the result.
  - gcd_result_taken is never asserted in ISSUE.
- Only one request is outstanding at a time.
- Back-to-back throughput: minimum 3 cycles plus GCD compute time plus downstream wait.
- Operand order is free; the GCD unit swaps internally. Zero operands are passed through unchanged: gcd(x,0) = x and gcd(0,0) = 0.

Decomposition:
- Shared package gcd_pkg holds:
  - State localparams IDLE, ISSUE, BUSY, RESP.
  - Default WIDTH = 16, LAT_W = 8, TIMEOUT = 200.
  - These values are also used by the GCD datapath and control.
- One sub-module, gcd_sat_counter: a LAT_W saturating up-counter with synchronous clear and enable, instantiated for the latency/timeout count.
- The FSM and capture registers stay in gcd_client.

Test Plan:
- Basic request against the real GCD unit: req (48,18) → exactly one gcd_input_available pulse; then resp_valid with resp_gcd=6, resp_timeout=0, resp_latency equal to the counted BUSY cycles; gcd_result_taken high in the cycle gcd_result_rdy is first seen.
- Operand order and zero handling:
  - (18,48) → 6.
  - (7,0) → 7.
  - (0,0) → 0.
  - (65535,1) → 1.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_gcd and resp_latency stay stable, req_ready stays 0, and no second gcd_input_available occurs; release → IDLE next cycle.
- Timeout: TIMEOUT=10 with a stub that never raises result_rdy → after 10 BUSY cycles resp_timeout=1, resp_gcd=0, resp_latency=10, err=1; err stays 1 across later successful requests.
- Stale flush: the stub raises result_rdy 3 cycles after the timeout, while the block is in RESP → gcd_result_taken=1 that cycle and the response contents are unchanged.
- Reset mid-BUSY: assert reset for 1 cycle during BUSY → next cycle state=IDLE, req_ready=1, resp_valid=0, err=0, and no response is emitted for the dropped request.
